// File: rtl/pingpong_feed_pkg.sv
// Shared types and constants for the ping-pong operand staging buffer.
package pingpong_feed_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/pingpong_bank.sv
// One DEPTH x DATA_W flop bank: single write port, combinational read port.
module pingpong_bank
  import pingpong_feed_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is cleared on reset so a discarded tile can never reappear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pingpong_feed.sv
// Ping-pong staging buffer feeding the 2:1 operand mux of the systolic array:
// one bank fills from the producer while the other drains toward the array.
module pingpong_feed
  import pingpong_feed_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout_1,
  output logic              sel
);

  localparam int CNT_W = ADDR_W + 1;

  // Handshake: a transfer fires on a cycle where valid and ready are both high.
  // Ready/valid depend only on registered state; the producer holds data and
  // last while valid is high and ready is low.

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              wr_fire, wr_close;
  logic              rd_fire, rd_done;
  logic [DATA_W-1:0] rdata [2];

  assign wr_fire  = wr_valid && wr_ready;
  assign wr_close = wr_fire && (wr_last || (wr_addr_q == ADDR_W'(DEPTH - 1)));
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_done  = rd_fire && rd_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Write and read fires always target opposite banks (EMPTY vs FULL), so
  // both updates below can apply in the same cycle without conflict.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    if (wr_fire) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      if (wr_close) begin
        state_d[wr_bank_q] = BANK_FULL;
        cnt_d[wr_bank_q]   = {1'b0, wr_addr_q} + CNT_W'(1);
        wr_addr_d          = '0;
        wr_bank_d          = ~wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (rd_done) begin
        state_d[rd_bank_q] = BANK_EMPTY;
        rd_addr_d          = '0;
        rd_bank_d          = ~rd_bank_q;
      end
    end
  end

  always_comb begin
    wr_ready = (state_q[wr_bank_q] == BANK_EMPTY);
    rd_valid = (state_q[rd_bank_q] == BANK_FULL);
    rd_last  = rd_valid && ({1'b0, rd_addr_q} == (cnt_q[rd_bank_q] - CNT_W'(1)));
    sel      = rd_bank_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (wr_fire && (wr_bank_q == 1'(b))),
      .waddr (wr_addr_q),
      .wdata (wr_data),
      .raddr (rd_addr_q),
      .rdata (rdata[b])
    );
  end

  assign dout_0 = rdata[0];
  assign dout_1 = rdata[1];

endmodule
